// File: rtl/shiftdiv_param.sv
// ---------------------------------------------------------------------------
// shiftdiv_param
//   Sequential restoring divider with one quotient bit per cycle.
//   It supports signed and unsigned operation, selected per operation.
//   The operands are captured when the divider accepts a start.
//   A divide by zero is detected in IDLE and finishes in two cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   start        request; acted on only while ready=1
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   dividend     numerator   (sampled with start)
//   divisor      denominator (sampled with start)
//   ready        idle and able to accept start
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     result, held until the next FIX/ZERO update
//   remainder    result, held until the next FIX/ZERO update
//   div_by_zero  set with done when divisor==0, held with the results
//
// Latency from the accepting edge to done: WIDTH+2 cycles for a normal
// divide, 2 cycles for a divide by zero.
// ---------------------------------------------------------------------------
module shiftdiv_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_sh;    // dividend magnitude; holds the raw dividend on the ZERO path
  logic [WIDTH-1:0] dvs_mag;   // divisor magnitude
  logic [WIDTH-1:0] part_rem;  // partial remainder
  logic [WIDTH-1:0] quo_sh;    // quotient bits, shifted in from the LSB
  logic             neg_q;
  logic             neg_r;

  // The trial value is one bit wider than the operands.
  // The partial remainder can reach divisor-1.
  // With a large unsigned divisor, the top bit of the partial remainder
  // would be lost if the shifted value were truncated to WIDTH bits.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  assign trial = {part_rem, dvd_sh[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_mag};
  assign fits  = ~diff[WIDTH];   // no borrow, so trial >= divisor magnitude

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    // For the most-negative value, -v equals v (2^(WIDTH-1)).
    // That is still the correct unsigned magnitude.
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  // NOTE: every register in this block uses non-blocking assignment.
  // That way all state updates in one edge see the values from before the
  // edge. The unconditional done <= 0 below is overridden later in the same
  // block, which makes done a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      dvd_sh      <= '0;
      dvs_mag     <= '0;
      part_rem    <= '0;
      quo_sh      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          count <= '0;
          if (start) begin
            ready    <= 1'b0;
            neg_q    <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= signed_mode & dividend[WIDTH-1];
            part_rem <= '0;
            quo_sh   <= '0;
            dvs_mag  <= magnitude(divisor, signed_mode);
            if (divisor == '0) begin
              dvd_sh <= dividend;
              state  <= ZERO;
            end else begin
              dvd_sh <= magnitude(dividend, signed_mode);
              state  <= CALC;
            end
          end
        end

        CALC: begin
          part_rem <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_sh   <= {quo_sh[WIDTH-2:0], fits};
          dvd_sh   <= dvd_sh << 1;
          if (count == LAST) begin
            state <= FIX;
          end else begin
            count <= count + 1'b1;
          end
        end

        FIX: begin
          quotient    <= neg_q ? -quo_sh : quo_sh;
          remainder   <= neg_r ? -part_rem : part_rem;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          ready       <= 1'b1;
          state       <= IDLE;
        end

        ZERO: begin
          quotient    <= '1;
          remainder   <= dvd_sh;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          ready       <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
